// File: rtl/alu_issue_sequencer_if.sv
// Issue/capture bus between an upstream source, the sequencer and the ALU.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface alu_issue_sequencer_if #(
  parameter int WIDTH = 32
);
  // request side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_cmd;
  // ALU drive and return
  logic [WIDTH-1:0] alu_operandA;
  logic [WIDTH-1:0] alu_operandB;
  logic [2:0]       alu_command;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carryout;
  logic             alu_zero;
  logic             alu_overflow;
  // result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_cmd;
  logic             out_carryout;
  logic             out_zero;
  logic             out_overflow;
  // status
  logic             sticky_overflow;
  logic             clear_sticky;
  logic             busy;

  // sequencer side
  modport slave (
    input  in_valid, in_a, in_b, in_cmd,
    input  alu_result, alu_carryout, alu_zero, alu_overflow,
    input  out_ready, clear_sticky,
    output in_ready,
    output alu_operandA, alu_operandB, alu_command,
    output out_valid, out_result, out_cmd, out_carryout, out_zero, out_overflow,
    output sticky_overflow, busy
  );

  // environment side: upstream source, ALU and result consumer
  modport master (
    output in_valid, in_a, in_b, in_cmd,
    output alu_result, alu_carryout, alu_zero, alu_overflow,
    output out_ready, clear_sticky,
    input  in_ready,
    input  alu_operandA, alu_operandB, alu_command,
    input  out_valid, out_result, out_cmd, out_carryout, out_zero, out_overflow,
    input  sticky_overflow, busy
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Registers one ALU operation, holds the ALU inputs while the slow ALU settles, then captures result and flags.
// Latency: exactly SETTLE_CYCLES edges from accept to out_valid; one op per SETTLE_CYCLES+1 edges sustained.
// Backpressure: in_ready only in IDLE or in DONE with out_ready; results and ALU inputs hold while out_ready is low.
module alu_issue_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_issue_sequencer_if.slave bus
);

  localparam logic [1:0]       S_IDLE   = 2'd0;
  localparam logic [1:0]       S_SETTLE = 2'd1;
  localparam logic [1:0]       S_DONE   = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       ocmd_q, ocmd_d;
  logic             oc_q, oc_d;
  logic             oz_q, oz_d;
  logic             ov_q, ov_d;
  logic             ovld_q, ovld_d;
  logic             sticky_q, sticky_d;

  logic accept;
  logic capture;
  logic arith_cmd;
  logic masked_ov;

  // A finished result may retire and a new request enter on the same edge.
  assign bus.in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign capture      = (state_q == S_SETTLE) && (cnt_q == '0);
  // Carry and overflow only mean something for add, sub and slt.
  assign arith_cmd    = (cmd_q == 3'b000) | (cmd_q == 3'b001) | (cmd_q == 3'b011);
  assign masked_ov    = arith_cmd & bus.alu_overflow;

  // Next-state: settle countdown, capture, retire, and (re)load on accept.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cmd_d    = cmd_q;
    res_d    = res_q;
    ocmd_d   = ocmd_q;
    oc_d     = oc_q;
    oz_d     = oz_q;
    ov_d     = ov_q;
    ovld_d   = ovld_q;
    sticky_d = sticky_q;

    case (state_q)
      S_IDLE: ;
      S_SETTLE: begin
        if (capture) begin
          res_d   = bus.alu_result;
          ocmd_d  = cmd_q;
          oc_d    = arith_cmd & bus.alu_carryout;
          oz_d    = bus.alu_zero;
          ov_d    = masked_ov;
          ovld_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          ovld_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // accept is only possible in IDLE or retiring DONE, so it overrides the state choice above
    if (accept) begin
      opa_d   = bus.in_a;
      opb_d   = bus.in_b;
      cmd_d   = bus.in_cmd;
      cnt_d   = CNT_LOAD;
      state_d = S_SETTLE;
    end

    // a capture that sets the bit beats a coincident clear
    if (capture && masked_ov) begin
      sticky_d = 1'b1;
    end else if (bus.clear_sticky) begin
      sticky_d = 1'b0;
    end
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cmd_q    <= '0;
      res_q    <= '0;
      ocmd_q   <= '0;
      oc_q     <= 1'b0;
      oz_q     <= 1'b0;
      ov_q     <= 1'b0;
      ovld_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cmd_q    <= cmd_d;
      res_q    <= res_d;
      ocmd_q   <= ocmd_d;
      oc_q     <= oc_d;
      oz_q     <= oz_d;
      ov_q     <= ov_d;
      ovld_q   <= ovld_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.alu_operandA    = opa_q;
  assign bus.alu_operandB    = opb_q;
  assign bus.alu_command     = cmd_q;
  assign bus.out_valid       = ovld_q;
  assign bus.out_result      = res_q;
  assign bus.out_cmd         = ocmd_q;
  assign bus.out_carryout    = oc_q;
  assign bus.out_zero        = oz_q;
  assign bus.out_overflow    = ov_q;
  assign bus.sticky_overflow = sticky_q;
  assign bus.busy            = (state_q == S_SETTLE) | (state_q == S_DONE);

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed plus randomized bench for alu_issue_sequencer with a bit-level ALU stand-in and an arithmetic reference model.
// Latency: expects out_valid exactly SETTLE edges after each accept.
// Backpressure: exercises held results with out_ready low and same-edge retire/accept.
module tb_alu_issue_sequencer;

  localparam int W      = 32;
  localparam int SETTLE = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_sequencer_if #(.WIDTH(W)) bus ();

  alu_issue_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ALU stand-in: junk drives carry/overflow for logic commands, perturb corrupts every ALU output
  logic        junk;
  logic        perturb;
  logic [31:0] opa, opb;
  logic [32:0] wide;
  logic [31:0] r_m;
  logic        c_m, v_m;

  assign opa = bus.alu_operandA;
  assign opb = bus.alu_operandB;

  // combinational ALU behaviour from two's-complement bit rules
  always_comb begin
    wide = '0;
    r_m  = '0;
    c_m  = junk;
    v_m  = junk;
    case (bus.alu_command)
      3'b000: begin
        wide = {1'b0, opa} + {1'b0, opb};
        r_m  = wide[31:0];
        c_m  = wide[32];
        v_m  = (opa[31] == opb[31]) && (wide[31] != opa[31]);
      end
      3'b001, 3'b011: begin
        wide = {1'b0, opa} + {1'b0, ~opb} + 33'd1;
        c_m  = wide[32];
        v_m  = (opa[31] != opb[31]) && (wide[31] != opa[31]);
        r_m  = (bus.alu_command == 3'b011) ? {31'b0, wide[31] ^ v_m} : wide[31:0];
      end
      3'b010:  r_m = opa ^ opb;
      3'b100:  r_m = opa & opb;
      3'b101:  r_m = ~(opa & opb);
      3'b110:  r_m = ~(opa | opb);
      default: r_m = opa | opb;
    endcase
  end

  assign bus.alu_result   = perturb ? ~r_m : r_m;
  assign bus.alu_carryout = c_m ^ perturb;
  assign bus.alu_zero     = (r_m == '0) ^ perturb;
  assign bus.alu_overflow = v_m ^ perturb;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] exp_r;
  logic [2:0]  exp_cmd;
  logic        exp_c, exp_z, exp_v;
  logic        exp_sticky = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // reference: signed/unsigned integer arithmetic, overflow = result does not fit 32 signed bits
  task automatic ref_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd,
                        output logic [31:0] r, output logic c, output logic z, output logic v);
    longint sa, sb, full;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    full = 0;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (cmd)
      3'd0: begin full = sa + sb; r = 32'(full); c = (ua + ub) > 64'hFFFF_FFFF; v = (full != longint'($signed(r))); end
      3'd1: begin full = sa - sb; r = 32'(full); c = (ua >= ub); v = (full != longint'($signed(32'(full)))); end
      3'd3: begin full = sa - sb; r = (sa < sb) ? 32'd1 : 32'd0; c = (ua >= ub); v = (full != longint'($signed(32'(full)))); end
      3'd2: r = a ^ b;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    z = (r == 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // present a request, take it on the next edge, and check the ALU drive registers
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cmd   = cmd;
    bus.in_valid = 1'b1;
    #1;
    chk("in_ready_pre_accept", 64'(bus.in_ready), 64'd1);
    cyc();
    bus.in_valid = 1'b0;
    chk("alu_operandA", 64'(bus.alu_operandA), 64'(a));
    chk("alu_operandB", 64'(bus.alu_operandB), 64'(b));
    chk("alu_command", 64'(bus.alu_command), 64'(cmd));
    chk("out_valid_after_accept", 64'(bus.out_valid), 64'd0);
    chk("busy_settle", 64'(bus.busy), 64'd1);
    ref_op(a, b, cmd, exp_r, exp_c, exp_z, exp_v);
    exp_cmd = cmd;
  endtask

  // count edges to out_valid and compare the captured result against the reference
  task automatic wait_result();
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk("latency", 64'(n), 64'(SETTLE));
    chk("out_result", 64'(bus.out_result), 64'(exp_r));
    chk("out_cmd", 64'(bus.out_cmd), 64'(exp_cmd));
    chk("out_carryout", 64'(bus.out_carryout), 64'(exp_c));
    chk("out_zero", 64'(bus.out_zero), 64'(exp_z));
    chk("out_overflow", 64'(bus.out_overflow), 64'(exp_v));
    exp_sticky = exp_sticky | exp_v;
    chk("sticky_overflow", 64'(bus.sticky_overflow), 64'(exp_sticky));
  endtask

  // with out_ready low, the captured result and the ALU drive must not move
  task automatic hold_check(input int cycles, input logic [31:0] held_a);
    for (int k = 0; k < cycles; k++) begin
      cyc();
      chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_out_result", 64'(bus.out_result), 64'(exp_r));
      chk("hold_flags", 64'({bus.out_carryout, bus.out_zero, bus.out_overflow}), 64'({exp_c, exp_z, exp_v}));
      chk("hold_alu_operandA", 64'(bus.alu_operandA), 64'(held_a));
    end
  endtask

  task automatic clear_pulse();
    bus.clear_sticky = 1'b1;
    cyc();
    bus.clear_sticky = 1'b0;
    exp_sticky = 1'b0;
    chk("sticky_cleared", 64'(bus.sticky_overflow), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        seen;
    logic [31:0] ra, rb;
    logic [2:0]  rc;

    bus.in_valid     = 1'b0;
    bus.in_a         = '0;
    bus.in_b         = '0;
    bus.in_cmd       = '0;
    bus.out_ready    = 1'b1;
    bus.clear_sticky = 1'b0;
    junk             = 1'b0;
    perturb          = 1'b0;

    // reset state
    repeat (3) cyc();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_alu_drive", 64'({bus.alu_operandA, bus.alu_command}), 64'd0);
    chk("rst_out_regs", 64'({bus.out_result, bus.out_cmd, bus.out_carryout, bus.out_zero, bus.out_overflow}), 64'd0);
    chk("rst_sticky", 64'(bus.sticky_overflow), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

    // signed overflow on add
    issue(32'h7FFF_FFFF, 32'h0000_0001, 3'b000);
    wait_result();
    // equal subtract: zero, no borrow; then clear sticky
    issue(32'h5, 32'h5, 3'b001);
    wait_result();
    clear_pulse();
    // slt both ways
    issue(32'hFFFF_FFFF, 32'h1, 3'b011);
    wait_result();
    issue(32'h1, 32'hFFFF_FFFF, 3'b011);
    wait_result();
    // xor with garbage carry/overflow from the ALU must be masked, sticky untouched
    junk = 1'b1;
    issue(32'hFFFF_FFFF, 32'h0, 3'b010);
    wait_result();
    junk = 1'b0;

    // backpressure: held result while a new request waits and the ALU outputs wobble
    issue(32'h0F0F_0F0F, 32'h00FF_00FF, 3'b100);
    bus.out_ready = 1'b0;
    wait_result();
    bus.in_a     = 32'h1;
    bus.in_b     = 32'h2;
    bus.in_cmd   = 3'b000;
    bus.in_valid = 1'b1;
    perturb      = 1'b1;
    hold_check(10, 32'h0F0F_0F0F);
    perturb       = 1'b0;
    bus.out_ready = 1'b1;
    issue(32'h1, 32'h2, 3'b000);
    wait_result();

    // set and clear on the same edge: set wins, next clear-only edge clears
    bus.clear_sticky = 1'b1;
    exp_sticky = 1'b0;
    issue(32'h7FFF_FFFF, 32'h1, 3'b000);
    wait_result();
    cyc();
    exp_sticky = 1'b0;
    chk("sticky_clear_after_set", 64'(bus.sticky_overflow), 64'd0);
    bus.clear_sticky = 1'b0;

    // reset in the middle of a settle window discards the operation
    issue(32'h7FFF_FFFF, 32'h1, 3'b000);
    wait_result();
    issue(32'h5, 32'h5, 3'b001);
    wait_result();
    issue(32'h1234_5678, 32'h1, 3'b000);
    cyc();
    #1;
    rst_n = 1'b0;
    #1;
    exp_sticky = 1'b0;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_alu_drive", 64'({bus.alu_operandA, bus.alu_command}), 64'd0);
    chk("midrst_alu_operandB", 64'(bus.alu_operandB), 64'd0);
    chk("midrst_out_regs", 64'({bus.out_result, bus.out_cmd, bus.out_carryout, bus.out_zero, bus.out_overflow}), 64'd0);
    chk("midrst_sticky", 64'(bus.sticky_overflow), 64'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      seen = seen | bus.out_valid;
    end
    chk("no_out_valid_after_reset", 64'(seen), 64'd0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000);
    wait_result();

    // randomized operations with random backpressure and occasional sticky clears
    for (int i = 0; i < 40; i++) begin
      ra = pick();
      rb = pick();
      rc = 3'($urandom_range(0, 7));
      junk = 1'($urandom_range(0, 1));
      issue(ra, rb, rc);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      wait_result();
      if (!bus.out_ready) begin
        junk = ~junk;
        hold_check(int'($urandom_range(1, 4)), ra);
        bus.out_ready = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) clear_pulse();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Upstream issue/capture stage for the 32-bit gate-level ALU.
- Accepts one operation per valid/ready handshake and drives the ALU operand and command inputs from registers.
- Holds those inputs stable for a fixed number of settle cycles, because the ALU's ripple-carry and zero-detect paths exceed one clock period. Then captures result and flags into an output register with its own valid/ready handshake.
- Also masks meaningless flags for logic commands and keeps a sticky overflow bit.

Parameters:
- WIDTH, 32, operand and result width; must match the ALU.
- SETTLE_CYCLES, 4, clock edges from accept to capture; legal values 1..15.
- CNT_W, 4, settle counter width; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  sequencer can accept a request this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cmd  input  3  ALU command: 000 add, 001 sub, 010 xor, 011 slt, 100 and, 101 nand, 110 nor, 111 or.
- alu_operandA  output  WIDTH  registered operand A to the ALU.
- alu_operandB  output  WIDTH  registered operand B to the ALU.
- alu_command  output  3  registered command to the ALU.
- alu_result  input  WIDTH  ALU result.
- alu_carryout, alu_zero, alu_overflow  input  1 each  ALU flags.
- out_valid  output  1  captured result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  captured result.
- out_cmd  output  3  command that produced out_result.
- out_carryout, out_zero, out_overflow  output  1 each  captured flags, masked as described under Behaviour.
- sticky_overflow  output  1  set by any captured add/sub/slt overflow.
- clear_sticky  input  1  synchronous clear of sticky_overflow.
- busy  output  1  high in SETTLE and DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - alu_operandA, alu_operandB, alu_command, out_result, out_cmd and all out_* flags are 0.
  - out_valid=0, sticky_overflow=0, busy=0, settle counter=0.
  - in_ready=1 once reset deasserts.
- States: IDLE, SETTLE, DONE.
- in_ready (combinational) = (state==IDLE) | (state==DONE & out_ready).
- Accept occurs on an edge with in_valid & in_ready:
  - load in_a, in_b and in_cmd into the alu_* registers;
  - load the counter with SETTLE_CYCLES-1;
  - go to SETTLE.
- SETTLE:
  - alu_* registers hold.
  - If counter!=0, decrement.
  - If counter==0, capture on this edge: load out_result, out_cmd and the flags; set out_valid=1; go to DONE.
  - Accept-to-out_valid latency is exactly SETTLE_CYCLES edges. SETTLE_CYCLES=1 captures on the first edge after accept.
- Flag masking at capture:
  - cmd 000/001/011: out_carryout = alu_carryout, out_overflow = alu_overflow.
  - All other commands: out_carryout=0, out_overflow=0.
  - out_zero = alu_zero for every command.
- DONE:
  - out_* registers and alu_* registers hold while out_ready=0.
  - On out_ready=1 with no new accept in the same edge: out_valid falls, go to IDLE.
  - On out_ready=1 with in_valid=1: the result retires and the new request is accepted on the same edge; go to SETTLE; out_valid falls.
- Sustained throughput is one operation per SETTLE_CYCLES+1 edges.
- sticky_overflow:
  - set on any capture edge where the masked overflow is 1;
  - cleared on an edge with clear_sticky=1 and no set;
  - if set and clear coincide, set wins.
- in_valid while in SETTLE or in DONE with out_ready=0: ignored. The upstream source must hold its request.
- Reset during SETTLE or DONE: the in-flight operation is discarded and no out_valid is produced.
- Flag, operand and command changes on the ALU inputs outside the capture edge never alter out_* registers.

Test Plan:
- Reset release, then cmd=000, a=0x7FFFFFFF, b=0x00000001, out_ready=1 -> out_valid exactly 4 edges after accept; out_result=0x80000000, out_overflow=1, out_carryout=0, sticky_overflow=1.
- cmd=001, a=b=0x00000005 -> out_result=0, out_zero=1, out_carryout=1, out_overflow=0. Then pulse clear_sticky -> sticky_overflow=0.
- cmd=011, a=0xFFFFFFFF, b=0x00000001 -> out_result=0x00000001, out_zero=0. Then cmd=011 with a=1, b=0xFFFFFFFF -> out_result=0, out_zero=1.
- cmd=010, a=0xFFFFFFFF, b=0; the ALU model forces alu_overflow=1 and alu_carryout=1 -> out_result=0xFFFFFFFF, out_overflow=0, out_carryout=0, sticky unchanged.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid with in_valid=1 and new operands -> out_* and alu_* stable, in_ready=0. Raise out_ready -> next request accepted on that edge; next result appears 4 edges later.
- rst_n pulsed low mid-SETTLE (counter=2) -> all outputs 0 immediately, no out_valid afterwards. A fresh request after release completes with normal latency.
